// File: rtl/kse_jtag_cmd_exec.sv
// Executes KSE JTAG TDR commands: KSE3 access-mode / ADAC-init handshakes or a
// single AHB-Lite transfer toward KSE3, reporting status back to the TDR core.
module kse_jtag_cmd_exec #(
    parameter int AddrW      = 32,
    parameter int DataW      = 32,
    parameter int KseTimeout = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [AddrW-1:0] i_ahb_haddr,
    input  logic [DataW-1:0] i_ahb_hwdata,
    input  logic             i_ahb_hwrite,
    input  logic             i_ahb_valid,
    input  logic             i_enter_jtag_access_mode,
    input  logic             i_init_kse3_adac_itf,
    input  logic             i_jtag_dbg,
    input  logic             i_transaction_id,
    output logic [DataW-1:0] o_ahb_hrdata,
    output logic             o_jtag_ready,
    output logic             o_jtag_kse_error,
    output logic             o_jtag_ahb_error,
    output logic             o_jtag_cmd_ignored,
    output logic [AddrW-1:0] o_haddr,
    output logic [DataW-1:0] o_hwdata,
    output logic             o_hwrite,
    output logic [1:0]       o_htrans,
    output logic [2:0]       o_hsize,
    input  logic             i_hready,
    input  logic             i_hresp,
    input  logic [DataW-1:0] i_hrdata,
    output logic             o_kse_enter_access,
    output logic             o_kse_init_adac,
    input  logic             i_kse_ack,
    input  logic             i_kse_error,
    output logic             o_jtag_access_mode,
    output logic             o_jtag_dbg_en
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam int         CntW          = (KseTimeout > 1) ? $clog2(KseTimeout) : 1;

    typedef enum logic [2:0] {S_IDLE, S_KSE_WAIT, S_AHB_ADDR, S_AHB_DATA, S_RESP} state_t;
    state_t r_state, w_next;

    logic             r_last_id;
    logic [CntW-1:0]  r_cnt;
    logic             r_is_enter;
    logic [AddrW-1:0] r_haddr;
    logic [DataW-1:0] r_hwdata;
    logic             r_hwrite;
    logic [DataW-1:0] r_hrdata;
    logic             r_ready, r_kse_err, r_ahb_err, r_ignored;
    logic             r_enter_pulse, r_init_pulse, r_access_mode, r_dbg_en;

    logic w_new_cmd, w_accept, w_kse_cmd, w_misaligned, w_ahb_go, w_timeout;

    assign w_new_cmd    = (i_transaction_id != r_last_id);
    assign w_accept     = w_new_cmd && (r_state == S_IDLE);
    assign w_kse_cmd    = i_enter_jtag_access_mode || i_init_kse3_adac_itf;
    assign w_misaligned = (i_ahb_haddr[1:0] != 2'b00);
    assign w_ahb_go     = !w_kse_cmd && i_ahb_valid && r_access_mode && !w_misaligned;
    assign w_timeout    = (r_cnt == CntW'(KseTimeout - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_kse_cmd) w_next = S_KSE_WAIT;
                else if (w_accept && w_ahb_go) w_next = S_AHB_ADDR;
            end
            S_KSE_WAIT: if (i_kse_ack || w_timeout) w_next = S_RESP;
            S_AHB_ADDR: if (i_hready) w_next = S_AHB_DATA;
            S_AHB_DATA: if (i_hready) w_next = S_RESP;
            S_RESP:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_id     <= 1'b0;
            r_cnt         <= '0;
            r_is_enter    <= 1'b0;
            r_haddr       <= '0;
            r_hwdata      <= '0;
            r_hwrite      <= 1'b0;
            r_hrdata      <= '0;
            r_ready       <= 1'b1;
            r_kse_err     <= 1'b0;
            r_ahb_err     <= 1'b0;
            r_ignored     <= 1'b0;
            r_enter_pulse <= 1'b0;
            r_init_pulse  <= 1'b0;
            r_access_mode <= 1'b0;
            r_dbg_en      <= 1'b0;
        end else begin
            r_enter_pulse <= 1'b0;
            r_init_pulse  <= 1'b0;
            if (w_new_cmd) r_last_id <= i_transaction_id;
            // A toggle while busy only flags the drop; the running command is untouched.
            if (w_new_cmd && r_state != S_IDLE) r_ignored <= 1'b1;

            if (w_accept) begin
                r_kse_err  <= 1'b0;
                r_ahb_err  <= 1'b0;
                r_ignored  <= 1'b0;
                r_ready    <= 1'b0;
                r_haddr    <= i_ahb_haddr;
                r_hwdata   <= i_ahb_hwdata;
                r_hwrite   <= i_ahb_hwrite;
                r_dbg_en   <= i_jtag_dbg;
                r_is_enter <= i_enter_jtag_access_mode;
                r_cnt      <= '0;
                if (i_enter_jtag_access_mode)  r_enter_pulse <= 1'b1;
                else if (i_init_kse3_adac_itf) r_init_pulse  <= 1'b1;
                else if (!i_ahb_valid)         r_ready       <= 1'b1;
                else if (!w_ahb_go) begin
                    r_ready   <= 1'b1;
                    r_ignored <= 1'b1;
                    r_ahb_err <= w_misaligned;
                end
            end

            case (r_state)
                S_KSE_WAIT: begin
                    if (i_kse_ack) begin
                        r_kse_err <= i_kse_error;
                        if (r_is_enter && !i_kse_error) r_access_mode <= 1'b1;
                    end else if (w_timeout) r_kse_err <= 1'b1;
                    else                    r_cnt     <= r_cnt + 1'b1;
                end
                S_AHB_DATA: begin
                    if (i_hready) begin
                        r_ahb_err <= i_hresp;
                        if (!r_hwrite && !i_hresp) r_hrdata <= i_hrdata;
                    end
                end
                default: ;
            endcase

            // Ready is presented in RESP so the TDR sees it one cycle after completion.
            if (r_state != S_RESP && w_next == S_RESP) r_ready <= 1'b1;
        end
    end

    assign o_ahb_hrdata       = r_hrdata;
    assign o_jtag_ready       = r_ready;
    assign o_jtag_kse_error   = r_kse_err;
    assign o_jtag_ahb_error   = r_ahb_err;
    assign o_jtag_cmd_ignored = r_ignored;
    assign o_haddr            = r_haddr;
    assign o_hwdata           = r_hwdata;
    assign o_hwrite           = r_hwrite;
    assign o_htrans           = (r_state == S_AHB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign o_hsize            = 3'b010;
    assign o_kse_enter_access = r_enter_pulse;
    assign o_kse_init_adac    = r_init_pulse;
    assign o_jtag_access_mode = r_access_mode;
    assign o_jtag_dbg_en      = r_dbg_en;
endmodule

// File: tb/tb_kse_jtag_cmd_exec.sv
// Randomized scoreboard bench for kse_jtag_cmd_exec: the driver predicts each
// command's response from the command rules; a monitor compares at ready.
module tb_kse_jtag_cmd_exec;
    localparam int KT = 1024;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_ahb_haddr = '0, i_ahb_hwdata = '0;
    logic        i_ahb_hwrite = 0, i_ahb_valid = 0, i_enter_jtag_access_mode = 0;
    logic        i_init_kse3_adac_itf = 0, i_jtag_dbg = 0, i_transaction_id = 0;
    logic [31:0] o_ahb_hrdata;
    logic        o_jtag_ready, o_jtag_kse_error, o_jtag_ahb_error, o_jtag_cmd_ignored;
    logic [31:0] o_haddr, o_hwdata;
    logic        o_hwrite;
    logic [1:0]  o_htrans;
    logic [2:0]  o_hsize;
    logic        i_hready = 1, i_hresp = 0;
    logic [31:0] i_hrdata = '0;
    logic        o_kse_enter_access, o_kse_init_adac;
    logic        i_kse_ack = 0, i_kse_error = 0;
    logic        o_jtag_access_mode, o_jtag_dbg_en;

    kse_jtag_cmd_exec dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ahb_haddr(i_ahb_haddr), .i_ahb_hwdata(i_ahb_hwdata), .i_ahb_hwrite(i_ahb_hwrite),
        .i_ahb_valid(i_ahb_valid), .i_enter_jtag_access_mode(i_enter_jtag_access_mode),
        .i_init_kse3_adac_itf(i_init_kse3_adac_itf), .i_jtag_dbg(i_jtag_dbg),
        .i_transaction_id(i_transaction_id),
        .o_ahb_hrdata(o_ahb_hrdata), .o_jtag_ready(o_jtag_ready),
        .o_jtag_kse_error(o_jtag_kse_error), .o_jtag_ahb_error(o_jtag_ahb_error),
        .o_jtag_cmd_ignored(o_jtag_cmd_ignored),
        .o_haddr(o_haddr), .o_hwdata(o_hwdata), .o_hwrite(o_hwrite),
        .o_htrans(o_htrans), .o_hsize(o_hsize),
        .i_hready(i_hready), .i_hresp(i_hresp), .i_hrdata(i_hrdata),
        .o_kse_enter_access(o_kse_enter_access), .o_kse_init_adac(o_kse_init_adac),
        .i_kse_ack(i_kse_ack), .i_kse_error(i_kse_error),
        .o_jtag_access_mode(o_jtag_access_mode), .o_jtag_dbg_en(o_jtag_dbg_en)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic        kse, ahb, ign, acc, dbg;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, failures = 0;
    bit          mon_en = 1;
    logic        m_access = 0;
    logic [31:0] m_hrdata = '0;
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, o_jtag_ready, 1);
        chk({tag, "_htrans"}, o_htrans, 0);
        chk({tag, "_hsize"}, o_hsize, 3'b010);
        chk({tag, "_hrdata"}, o_ahb_hrdata, 0);
        chk({tag, "_haddr"}, o_haddr, 0);
        chk({tag, "_hwdata"}, o_hwdata, 0);
        chk({tag, "_flags"}, {o_jtag_kse_error, o_jtag_ahb_error, o_jtag_cmd_ignored, o_hwrite,
                              o_kse_enter_access, o_kse_init_adac, o_jtag_access_mode, o_jtag_dbg_en}, 0);
    endtask

    // Monitor: after each toggle, wait for ready and compare against the oldest prediction.
    initial begin
        logic prev;
        int   lat;
        bit   got;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_transaction_id != prev) begin
                prev = i_transaction_id;
                if (mon_en) begin
                    lat = 0;
                    got = 0;
                    while (!got && lat < 3000) begin
                        @(negedge i_clk);
                        lat++;
                        prev = i_transaction_id;
                        if (o_jtag_ready) got = 1;
                    end
                    if (!got) chk("ready_timeout", 0, 1);
                    else if (q.size() == 0) chk("unexpected_resp", 0, 1);
                    else begin
                        e = q.pop_front();
                        chk("latency", lat, e.lat);
                        chk("hrdata", o_ahb_hrdata, e.rd);
                        chk("kse_error", o_jtag_kse_error, e.kse);
                        chk("ahb_error", o_jtag_ahb_error, e.ahb);
                        chk("cmd_ignored", o_jtag_cmd_ignored, e.ign);
                        chk("access_mode", o_jtag_access_mode, e.acc);
                        chk("dbg_en", o_jtag_dbg_en, e.dbg);
                    end
                end
            end
        end
    end

    task automatic issue(input logic en, input logic ini, input logic val, input logic [31:0] addr,
                         input logic [31:0] wd, input logic wr, input logic dbg,
                         input int ack_cyc, input logic ack_err, input logic herr,
                         input int n0, input int n1in, input bit busy);
        exp_t        e;
        int          n1;
        bit          bus, kse;
        logic [31:0] rd;
        n1  = (herr && n1in == 0) ? 1 : n1in;
        kse = en || ini;
        bus = 0;
        rd  = mem.exists(addr) ? mem[addr] : $urandom;
        e.lat = 1; e.rd = m_hrdata; e.kse = 0; e.ahb = 0; e.ign = 0; e.dbg = dbg;
        if (kse) begin
            e.lat = (ack_cyc > 0) ? ack_cyc + 1 : KT + 1;
            e.kse = (ack_cyc > 0) ? ack_err : 1'b1;
            if (en && ack_cyc > 0 && !ack_err) m_access = 1;
        end else if (val) begin
            if (!m_access) e.ign = 1;
            else if (addr[1:0] != 0) begin
                e.ign = 1;
                e.ahb = 1;
            end else begin
                bus   = 1;
                e.lat = 3 + n0 + n1;
                e.ahb = herr;
                e.ign = busy;
                if (!herr) begin
                    if (wr) mem[addr] = wd;
                    else    e.rd = rd;
                end
            end
        end
        e.acc    = m_access;
        m_hrdata = e.rd;
        q.push_back(e);

        @(posedge i_clk); #1;
        i_ahb_haddr = addr; i_ahb_hwdata = wd; i_ahb_hwrite = wr; i_ahb_valid = val;
        i_enter_jtag_access_mode = en; i_init_kse3_adac_itf = ini; i_jtag_dbg = dbg;
        i_hrdata = wr ? $urandom : rd;
        i_hready = 1; i_hresp = 0; i_kse_ack = 0;
        i_transaction_id = ~i_transaction_id;
        for (int c = 1; c <= e.lat + 1; c++) begin
            @(posedge i_clk); #1;
            if (bus) begin
                i_hready = (c <= n0 + n1 + 2) ? (c == n0 + 1 || c == n0 + n1 + 2) : 1'b1;
                i_hresp  = herr && (c == n0 + n1 + 1 || c == n0 + n1 + 2);
                if (busy && c == 2) i_transaction_id = ~i_transaction_id;
            end
            i_kse_ack   = kse && (c == ack_cyc);
            i_kse_error = (c == ack_cyc) ? ack_err : 1'($urandom_range(0, 1));
            @(negedge i_clk);
            if (c < e.lat) chk("ready_low", o_jtag_ready, 0);
            if (c == 1) begin
                chk("htrans_c1", o_htrans, bus ? 2'b10 : 2'b00);
                chk("enter_pulse", o_kse_enter_access, en);
                chk("init_pulse", o_kse_init_adac, !en && ini);
                if (bus) begin
                    chk("haddr", o_haddr, addr);
                    chk("hwrite", o_hwrite, wr);
                    chk("hsize", o_hsize, 3'b010);
                end
            end
            if (c == 2) chk("pulses_c2", {o_kse_enter_access, o_kse_init_adac}, 0);
            if (bus && c == n0 + n1 + 2) begin
                chk("htrans_data", o_htrans, 0);
                if (wr) chk("hwdata", o_hwdata, wd);
            end
        end
        i_kse_ack = 0; i_hready = 1; i_hresp = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        en, ini, val, wr, dbg, aerr, herr;
        logic [31:0] addr;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset("reset");
        @(posedge i_clk); #1;
        i_rst = 0;

        issue(0, 0, 1, 32'h100, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);           // no access mode
        issue(1, 0, 0, 32'h0, 32'h0, 0, 1, 3, 0, 0, 0, 0, 0);             // enter access
        issue(0, 0, 1, 32'h40, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0, 0);     // write
        issue(0, 0, 1, 32'h40, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);            // read back
        issue(0, 0, 1, 32'h44, 32'h0, 0, 1, 0, 0, 1, 1, 1, 0);            // hresp error
        issue(0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);             // ADAC timeout
        issue(0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0);             // no-op clears
        issue(0, 0, 1, 32'h40, 32'h0, 0, 0, 0, 0, 0, 0, 5, 1);            // busy toggle
        issue(0, 0, 1, 32'h42, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);            // misaligned
        issue(1, 0, 0, 32'h0, 32'h0, 0, 0, 2, 1, 0, 0, 0, 0);             // enter with error

        for (int i = 0; i < 40; i++) begin
            en   = ($urandom_range(0, 5) == 0);
            ini  = ($urandom_range(0, 5) == 0);
            val  = ($urandom_range(0, 3) != 0);
            addr = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wr   = 1'($urandom_range(0, 1));
            dbg  = 1'($urandom_range(0, 1));
            aerr = ($urandom_range(0, 3) == 0);
            herr = ($urandom_range(0, 5) == 0);
            issue(en, ini, val, addr, $urandom, wr, dbg, $urandom_range(1, 6), aerr, herr,
                  $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        // Reset while in the data phase of a read.
        repeat (2) @(posedge i_clk);
        mon_en = 0;
        #1;
        i_ahb_haddr = 32'h40; i_ahb_valid = 1; i_ahb_hwrite = 0;
        i_enter_jtag_access_mode = 0; i_init_kse3_adac_itf = 0;
        i_hready = 1;
        i_transaction_id = ~i_transaction_id;
        @(posedge i_clk); #1;
        i_hready = 1;
        @(posedge i_clk); #1;
        i_hready = 0;
        i_rst = 1;
        @(negedge i_clk);
        chk("pre_reset_busy", o_jtag_ready, 0);
        @(posedge i_clk); #1;
        i_transaction_id = 0; i_ahb_valid = 0; i_ahb_haddr = 0; i_kse_ack = 1;
        @(negedge i_clk);
        check_reset("midreset");
        @(posedge i_clk); #1;
        i_rst = 0;
        @(negedge i_clk);
        @(posedge i_clk); #1;
        i_kse_ack = 0;
        @(negedge i_clk);
        check_reset("postreset");

        repeat (3) @(posedge i_clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
